// File: rtl/griffin_pkg.sv
// rtl/griffin_pkg.sv - shared Griffin field and batch constants
package griffin_pkg;

    localparam int N_BITS     = 254;
    localparam int STATE_SIZE = 3;
    localparam int NUM_LANES  = 13;
    localparam int BATCH_LEN  = STATE_SIZE * NUM_LANES;

    localparam logic [N_BITS-1:0] PRIME_MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef logic [N_BITS-1:0] felem_t;

endpackage

// File: rtl/griffin_adapter_drain.sv
// rtl/griffin_adapter_drain.sv - result buffer and output stream replay
module griffin_adapter_drain
    import griffin_pkg::*;
#(
    parameter int N_BITS     = griffin_pkg::N_BITS,
    parameter int STATE_SIZE = griffin_pkg::STATE_SIZE,
    parameter int NUM_LANES  = griffin_pkg::NUM_LANES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [N_BITS-1:0] load_data [STATE_SIZE][NUM_LANES],
    output logic              out_pend,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_BITS-1:0] m_data,
    output logic              m_last
);

    localparam int EW = $clog2(STATE_SIZE > 1 ? STATE_SIZE : 2);
    localparam int LW = $clog2(NUM_LANES > 1 ? NUM_LANES : 2);

    logic [N_BITS-1:0] outbuf [STATE_SIZE][NUM_LANES];
    logic [EW-1:0]     out_elem;
    logic [LW-1:0]     out_lane;
    logic              at_end;

    assign at_end  = (out_elem == EW'(STATE_SIZE - 1)) && (out_lane == LW'(NUM_LANES - 1));
    assign m_valid = out_pend;
    assign m_data  = outbuf[out_elem][out_lane];
    assign m_last  = out_pend && at_end;

    always_ff @(posedge clk) begin
        if (load) begin
            outbuf <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_pend <= 1'b0;
            out_elem <= '0;
            out_lane <= '0;
        end else if (load) begin
            out_pend <= 1'b1;
        end else if (out_pend && m_ready) begin
            if (at_end) begin
                out_pend <= 1'b0;
                out_elem <= '0;
                out_lane <= '0;
            end else if (out_elem == EW'(STATE_SIZE - 1)) begin
                out_elem <= '0;
                out_lane <= out_lane + 1'b1;
            end else begin
                out_elem <= out_elem + 1'b1;
            end
        end
    end

endmodule

// File: rtl/griffin_stream_adapter.sv
// rtl/griffin_stream_adapter.sv - stream batching front/back end for the griffin core
// Optional input range check: GRIFFIN_ADAPTER_RANGE_CHECK_EN
module griffin_stream_adapter
    import griffin_pkg::*;
#(
    parameter int                N_BITS        = griffin_pkg::N_BITS,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = griffin_pkg::PRIME_MODULUS,
    parameter int                STATE_SIZE    = griffin_pkg::STATE_SIZE,
    parameter int                NUM_LANES     = griffin_pkg::NUM_LANES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [N_BITS-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_BITS-1:0] m_data,
    output logic              m_last,
    output logic              perm_enable,
    output logic [N_BITS-1:0] perm_in  [STATE_SIZE][NUM_LANES],
    input  logic [N_BITS-1:0] perm_out [STATE_SIZE][NUM_LANES],
    input  logic              perm_done,
    output logic              busy,
    output logic              in_err
);

    localparam int BATCH = STATE_SIZE * NUM_LANES;
    localparam int CW    = $clog2(BATCH > 1 ? BATCH : 2);
    localparam int EW    = $clog2(STATE_SIZE > 1 ? STATE_SIZE : 2);
    localparam int LW    = $clog2(NUM_LANES > 1 ? NUM_LANES : 2);

    logic [CW-1:0]     in_cnt;
    logic [EW-1:0]     in_elem;
    logic [LW-1:0]     in_lane;
    logic              in_full;
    logic              out_pend;
    logic              s_fire;
    logic              done_fire;
    logic [N_BITS-1:0] in_value;

    assign s_ready   = !in_full && !busy;
    assign s_fire    = s_valid && s_ready;
    assign done_fire = busy && perm_done;

`ifdef GRIFFIN_ADAPTER_RANGE_CHECK_EN
    logic in_oor;
    assign in_oor   = (s_data >= PRIME_MODULUS);
    assign in_value = in_oor ? '0 : s_data;

    // The first element of a batch restarts the sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_err <= 1'b0;
        end else if (s_fire) begin
            if (in_cnt == '0) begin
                in_err <= in_oor;
            end else if (in_oor) begin
                in_err <= 1'b1;
            end
        end
    end
`else
    logic unused_prime;
    assign unused_prime = ^PRIME_MODULUS;
    assign in_value     = s_data;
    assign in_err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (s_fire) begin
            perm_in[in_elem][in_lane] <= in_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt      <= '0;
            in_elem     <= '0;
            in_lane     <= '0;
            in_full     <= 1'b0;
            busy        <= 1'b0;
            perm_enable <= 1'b0;
        end else begin
            if (s_fire) begin
                if (in_cnt == CW'(BATCH - 1)) begin
                    in_cnt  <= '0;
                    in_elem <= '0;
                    in_lane <= '0;
                    in_full <= 1'b1;
                end else begin
                    in_cnt <= in_cnt + 1'b1;
                    if (in_elem == EW'(STATE_SIZE - 1)) begin
                        in_elem <= '0;
                        in_lane <= in_lane + 1'b1;
                    end else begin
                        in_elem <= in_elem + 1'b1;
                    end
                end
            end
            // A previous result must have left the buffer before relaunching.
            if (in_full && !busy && !out_pend) begin
                busy        <= 1'b1;
                perm_enable <= 1'b1;
            end
            if (done_fire) begin
                busy        <= 1'b0;
                perm_enable <= 1'b0;
                in_full     <= 1'b0;
            end
        end
    end

    griffin_adapter_drain #(
        .N_BITS     (N_BITS),
        .STATE_SIZE (STATE_SIZE),
        .NUM_LANES  (NUM_LANES)
    ) u_drain (
        .clk       (clk),
        .reset     (reset),
        .load      (done_fire),
        .load_data (perm_out),
        .out_pend  (out_pend),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

endmodule

// File: doc/griffin_stream_adapter.md
# griffin_stream_adapter

Streaming front/back end for the batched Griffin permutation core (`griffin`). It collects a batch of `STATE_SIZE*NUM_LANES` field elements from a valid/ready input stream into the core's `inState` array and drives `enable` until `done`. It then captures `outState` and replays the permuted elements on a valid/ready output stream. The next batch may be loaded while the previous result drains.

## Interface
Parameters:
- `N_BITS`, 254: field element width.
- `PRIME_MODULUS`, BN254 scalar prime (`254'h30644e72…f0000001`): used only by the range check.
- `STATE_SIZE`, 3: elements per Griffin state.
- `NUM_LANES`, 13: parallel states per batch.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input element valid.
- `s_ready`  out  1  adapter accepts the input element.
- `s_data`  in  `N_BITS`  input element.
- `m_valid`  out  1  output element valid.
- `m_ready`  in  1  sink accepts the output element.
- `m_data`  out  `N_BITS`  permuted element.
- `m_last`  out  1  final element of the batch.
- `perm_enable`  out  1  to `griffin.enable`.
- `perm_in`  out  `[N_BITS-1:0] [STATE_SIZE][NUM_LANES]`  to `griffin.inState`.
- `perm_out`  in  same shape  from `griffin.outState`.
- `perm_done`  in  1  from `griffin.done`.
- `busy`  out  1  permutation in flight.
- `in_err`  out  1  sticky out-of-range flag (see Configuration).

## Operation
- Element order: stream index k (0..`STATE_SIZE*NUM_LANES`-1) maps to lane `k/STATE_SIZE`, element `k%STATE_SIZE`. Element k is written to `perm_in[k%STATE_SIZE][k/STATE_SIZE]`. Output uses the same order.
- Input side:
  - Counter `in_cnt` and flag `in_full`.
  - `s_ready = !in_full && !busy`.
  - On each accepted element, store it and increment `in_cnt`.
  - When the final element is accepted, `in_cnt` wraps to 0 and `in_full` is set.
- Launch: when `in_full && !busy && !out_pend`, set `busy` and `perm_enable` on the next edge.
  - `perm_in` is held stable while `busy` is high.
- Completion: on the first cycle `perm_done==1` with `busy==1`:
  - Copy `perm_out` into the output buffer.
  - Clear `busy`, `perm_enable` and `in_full`.
  - Set `out_pend`.
  - `perm_done` while not busy is ignored.
- Output side:
  - `m_valid = out_pend`.
  - `m_data = outbuf[out_cnt]`.
  - `m_last = out_pend && out_cnt==STATE_SIZE*NUM_LANES-1`.
  - On `m_valid && m_ready`, increment `out_cnt`. On the last element, wrap to 0 and clear `out_pend`.
- Overlap: input loading proceeds during output drain. Launch of the next batch waits for `out_pend==0`.
- Simultaneous events: launch and completion never coincide. An accept on the cycle `in_full` is being set is impossible because `s_ready` is low once full.
- Reset: clears all counters and flags. Resets `perm_enable`, `s_ready` gating, `m_valid`, `m_last`, `busy` and `in_err` to 0. Contents of `perm_in` and `outbuf` are don't-care. A reset mid-batch discards partial and in-flight data.

## Timing
- Input throughput: 1 element/cycle.
- `perm_enable` rises exactly 1 cycle after the edge that sets `in_full` (when the output side is idle).
- `perm_enable` falls and `m_valid` rises on the edge after `perm_done` is sampled high.
- Output throughput: 1 element/cycle when `m_ready` is held high.
- All outputs are registered except `s_ready`, `m_data` and `m_last`, which decode from registers only.
- Backpressure: `m_data` and `m_last` are stable while `m_valid && !m_ready`.

## Configuration
- `GRIFFIN_ADAPTER_RANGE_CHECK_EN` defined:
  - An accepted `s_data >= PRIME_MODULUS` is stored as 0.
  - `in_err` is set and held until the first element of the next batch is accepted (k==0). That acceptance clears `in_err` unless that element is itself out of range.
- Undefined: no comparator; elements are stored unchanged and `in_err` is tied to 0.

## Structure
- Shared package `griffin_pkg`:
  - BN254 `PRIME_MODULUS`.
  - `N_BITS`, `STATE_SIZE`, `NUM_LANES` defaults.
  - `felem_t` (`logic [N_BITS-1:0]`).
  - Batch element count constant.
- Sub-module `griffin_adapter_drain`: output buffer, `out_cnt`, `out_pend`, `m_*` handshake.
- The input side and launch control stay in the top.

## Test plan
- Full batch with the BN254 vectors (element 0 = `0x2f9538bc…7b8cf251`) and the real `griffin` core: stream 39 elements back-to-back.
  - Expect `perm_enable` 1 cycle after the 39th accept.
  - Expect output element 0 = `0x2fbfccf7…db78969d` and element 38 = `0x16afbfc9…8ee835d3`, with `m_last` only on element 38.
- Stub core (done 5 cycles after enable, `outState = inState+1`), input k = k: expect output k = k+1. Measure launch-to-`m_valid` latency = stub latency + 1.
- Output backpressure: toggle `m_ready` every other cycle.
  - Expect `m_data` stable while stalled.
  - Expect no drops or duplicates, and 39 transfers total.
- Overlap: load batch B (k+100) during drain of batch A.
  - Expect `s_ready` high during drain.
  - Expect launch of B exactly 1 cycle after A's `m_last` transfer; B's outputs = k+101.
- Reset after 20 accepted elements: then stream a fresh batch of 39.
  - Expect `s_ready` re-admits at k=0.
  - Expect correct stub results and no stale `m_valid`.
- With the range-check macro defined, element 5 = `PRIME_MODULUS`:
  - Expect `in_err` high from the next cycle and stub output 5 = 1.
  - Expect `in_err` cleared on the next batch's first accept.
